fft_stage_controller: RTL and testbench
=======================================

// Module: fft_stage_controller
// PURPOSE
//  Sequences the in-place radix-2 DIT FFT butterfly datapath over all log2(N) stages.
//  Per butterfly, issues the read-address pair (A, then B) plus the twiddle address.
//  Downstream, the butterfly and the 2-to-1 output multiplexor write both results back
//  over two cycles, using the delayed read pointer as the write pointer.
//  Between stages it drains the pipeline so no read overtakes a pending write.
//  Input data is already in bit-reversed order in memory (loaded upstream).
// PARAMETERS
//  SIZE      8   address width; N = 2**SIZE points, SIZE stages
//  PIPE_LAT  4   cycles from last rd_ptr of a stage to its last write-back (>=1)
//  STAGE_W   3   width of stage index; must satisfy 2**STAGE_W >= SIZE
// PORTS
//  clk       in   1         system clock, rising edge
//  rst       in   1         asynchronous, active-high reset
//  start     in   1         1-cycle pulse; starts a transform when idle
//  hold      in   1         stall request from downstream
//  rd_ptr    out  SIZE      data-memory read address
//  rd_en     out  1         rd_ptr valid this cycle
//  bf_valid  out  1         high on the A-address cycle of each butterfly
//  tw_addr   out  SIZE-1    twiddle ROM address, valid with bf_valid
//  stage     out  STAGE_W   current stage index 0..SIZE-1
//  busy      out  1         high from the cycle after start until done
//  done      out  1         1-cycle pulse after the final stage drains
// BEHAVIOUR
//  - Reset: all outputs are 0. The FSM goes to IDLE and all counters (stage, bf, phase, drain) clear.
//    Reset is honoured in any state; a transform in progress is abandoned with no done pulse.
//  - All outputs are registered. If start is sampled at edge k, the first rd_ptr is valid after edge k+1.
//  - FSM states: IDLE, RUN, DRAIN, DONE.
//      IDLE : start=1 -> RUN; stage=0, bf=0, phase=0, busy=1.
//      RUN  : phase=0 drives addr_a (bf_valid=1, tw_addr valid); phase=1 drives addr_b.
//             rd_en=1 in both phases. phase toggles every cycle.
//             On phase=1 with bf==N/2-1 -> DRAIN, loading drain counter with PIPE_LAT-1.
//             Otherwise, on phase=1, bf increments.
//      DRAIN: rd_en=0 and bf_valid=0 while the counter decrements to 0.
//             Then: if stage==SIZE-1 -> DONE; else stage+1, bf=0, phase=0 -> RUN.
//      DONE : done=1 and busy=0 for exactly 1 cycle -> IDLE.
//  - Address arithmetic for stage s and butterfly b:
//      span = 1<<s; pos = b & (span-1); grp = b>>s;
//      addr_a = (grp<<(s+1)) | pos;  addr_b = addr_a + span (no carry out, < N);
//      tw_addr = pos << (SIZE-1-s), truncated to SIZE-1 bits.
//  - hold is sampled only in RUN with phase=0.
//      While sampled high: rd_en=0, bf_valid=0, counters freeze, rd_ptr holds its last value.
//      If hold rises while phase=1, the B read still issues; the A/B pair is never split.
//      hold is ignored in DRAIN, DONE and IDLE.
//  - start is ignored while busy=1 or in DONE. A start coincident with deassertion of rst is ignored.
//  - Cycle count with no holds: SIZE*(N+PIPE_LAT) cycles from the first rd_en to done.
// STRUCTURE
//  - Shared package fft_pkg holds: FSM state typedef/encoding (IDLE, RUN, DRAIN, DONE),
//    the clog2 helper, and the default SIZE and PIPE_LAT constants shared with the datapath.
//  - One sub-module, fft_addr_gen: combinational (stage, bf) -> (addr_a, addr_b, tw_addr).
//    This module registers its outputs.
// TESTING (SIZE=3, PIPE_LAT=4)
//  - Reset mid-RUN (stage 1, bf 2) -> all outputs 0 the next cycle, no done pulse;
//    a later start restarts from stage 0.
//  - start pulse -> stage 0 rd_ptr = 0,1,2,3,4,5,6,7; tw_addr=0 on each bf_valid;
//    then 4 cycles with rd_en=0.
//  - Stage 1 -> rd_ptr = 0,2,1,3,4,6,5,7; tw_addr = 0,2,0,2.
//    Stage 2 -> rd_ptr = 0,4,1,5,2,6,3,7; tw_addr = 0,1,2,3.
//  - done asserts exactly 36 cycles after the first rd_en, for 1 cycle; busy falls with it.
//  - hold=1 for 3 cycles, rising on a phase=1 cycle -> the B read completes,
//    then 3 idle cycles with rd_ptr stable; the sequence resumes and done is delayed by 3.
//  - start pulsed during RUN and during DONE -> no effect; the address sequence and done timing are unchanged.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg
// Shared definitions for the radix-2 DIT FFT stage controller and its datapath:
//   - fft_state_t : controller FSM encoding (IDLE, RUN, DRAIN, DONE)
//   - fft_clog2   : ceiling log2 helper for sizing counters
//   - FFT_SIZE, FFT_PIPE_LAT : default address width and butterfly pipeline latency
package fft_pkg;

    localparam int FFT_SIZE     = 8;
    localparam int FFT_PIPE_LAT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_t;

    function automatic int fft_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen
// Combinational address generator for one radix-2 DIT butterfly.
// Ports:
//   i_stage   in   STAGE_W  stage index s (0..SIZE-1)
//   i_bf      in   SIZE-1   butterfly index b within the stage (0..N/2-1)
//   o_addr_a  out  SIZE     upper-leg data address
//   o_addr_b  out  SIZE     lower-leg data address (o_addr_a + 2**s)
//   o_tw_addr out  SIZE-1   twiddle ROM address
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int SIZE    = FFT_SIZE,
    parameter int STAGE_W = 3
) (
    input  logic [STAGE_W-1:0] i_stage,
    input  logic [SIZE-2:0]    i_bf,
    output logic [SIZE-1:0]    o_addr_a,
    output logic [SIZE-1:0]    o_addr_b,
    output logic [SIZE-2:0]    o_tw_addr
);

    logic [SIZE-1:0]    w_span;
    logic [SIZE-1:0]    w_bf_ext;
    logic [SIZE-1:0]    w_pos;
    logic [SIZE-1:0]    w_grp;
    logic [SIZE-1:0]    w_tw_full;
    // One bit wider than the stage so s+1 cannot wrap on the last stage.
    logic [STAGE_W:0]   w_grp_sh;
    logic [STAGE_W-1:0] w_tw_sh;

    always_comb begin
        w_span    = SIZE'(1) << i_stage;
        w_bf_ext  = {1'b0, i_bf};
        w_pos     = w_bf_ext & (w_span - SIZE'(1));
        w_grp     = w_bf_ext >> i_stage;
        w_grp_sh  = {1'b0, i_stage} + (STAGE_W+1)'(1);
        w_tw_sh   = STAGE_W'(SIZE-1) - i_stage;
        o_addr_a  = (w_grp << w_grp_sh) | w_pos;
        // bit s of addr_a is always 0, so this add never carries out.
        o_addr_b  = o_addr_a + w_span;
        w_tw_full = w_pos << w_tw_sh;
        o_tw_addr = w_tw_full[SIZE-2:0];
    end

endmodule

// File: rtl/fft_stage_controller.sv
// fft_stage_controller
// Sequences the in-place radix-2 DIT FFT over all SIZE stages: per butterfly it issues
// the A then B read address plus the twiddle address, and drains the butterfly pipeline
// between stages so no read overtakes a pending write-back.
// Ports:
//   clk       in   1        system clock, rising edge
//   rst       in   1        asynchronous active-high reset
//   start     in   1        1-cycle pulse; starts a transform when idle
//   hold      in   1        downstream stall request (sampled before each A read)
//   rd_ptr    out  SIZE     data-memory read address
//   rd_en     out  1        rd_ptr valid this cycle
//   bf_valid  out  1        high on the A-address cycle of each butterfly
//   tw_addr   out  SIZE-1   twiddle ROM address, valid with bf_valid
//   stage     out  STAGE_W  current stage index
//   busy      out  1        transform in progress
//   done      out  1        1-cycle pulse after the final stage drains
module fft_stage_controller
    import fft_pkg::*;
#(
    parameter int SIZE     = FFT_SIZE,
    parameter int PIPE_LAT = FFT_PIPE_LAT,
    parameter int STAGE_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hold,
    output logic [SIZE-1:0]    rd_ptr,
    output logic               rd_en,
    output logic               bf_valid,
    output logic [SIZE-2:0]    tw_addr,
    output logic [STAGE_W-1:0] stage,
    output logic               busy,
    output logic               done
);

    localparam int                 DRAIN_W    = (fft_clog2(PIPE_LAT) < 1) ? 1 : fft_clog2(PIPE_LAT);
    localparam logic [SIZE-2:0]    BF_LAST    = '1;
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(SIZE-1);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(PIPE_LAT-1);

    fft_state_t         r_state,   w_state_nxt;
    logic [STAGE_W-1:0] r_stage,   w_stage_nxt;
    logic [SIZE-2:0]    r_bf,      w_bf_nxt;
    logic               r_phase,   w_phase_nxt;
    logic [DRAIN_W-1:0] r_drain,   w_drain_nxt;
    logic [SIZE-1:0]    r_rd_ptr,  w_rd_ptr_nxt;
    logic               r_rd_en,   w_rd_en_nxt;
    logic               r_bf_vld,  w_bf_vld_nxt;
    logic [SIZE-2:0]    r_tw_addr, w_tw_addr_nxt;
    logic               r_busy,    w_busy_nxt;
    logic               r_done,    w_done_nxt;
    // Low for the first edge after reset release so a start held across release is dropped.
    logic               r_armed;

    logic [SIZE-1:0]    w_addr_a;
    logic [SIZE-1:0]    w_addr_b;
    logic [SIZE-2:0]    w_tw_addr;

    fft_addr_gen #(
        .SIZE    (SIZE),
        .STAGE_W (STAGE_W)
    ) u_addr_gen (
        .i_stage   (r_stage),
        .i_bf      (r_bf),
        .o_addr_a  (w_addr_a),
        .o_addr_b  (w_addr_b),
        .o_tw_addr (w_tw_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_stage   <= '0;
            r_bf      <= '0;
            r_phase   <= 1'b0;
            r_drain   <= '0;
            r_rd_ptr  <= '0;
            r_rd_en   <= 1'b0;
            r_bf_vld  <= 1'b0;
            r_tw_addr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_stage   <= w_stage_nxt;
            r_bf      <= w_bf_nxt;
            r_phase   <= w_phase_nxt;
            r_drain   <= w_drain_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_bf_vld  <= w_bf_vld_nxt;
            r_tw_addr <= w_tw_addr_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_armed   <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_stage_nxt   = r_stage;
        w_bf_nxt      = r_bf;
        w_phase_nxt   = r_phase;
        w_drain_nxt   = r_drain;
        w_rd_ptr_nxt  = r_rd_ptr;
        w_rd_en_nxt   = 1'b0;
        w_bf_vld_nxt  = 1'b0;
        w_tw_addr_nxt = r_tw_addr;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start && r_armed) begin
                    w_state_nxt = ST_RUN;
                    w_stage_nxt = '0;
                    w_bf_nxt    = '0;
                    w_phase_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_RUN: begin
                if (!r_phase) begin
                    // hold only gates the A read, so an issued A is always followed by its B.
                    if (!hold) begin
                        w_rd_ptr_nxt  = w_addr_a;
                        w_rd_en_nxt   = 1'b1;
                        w_bf_vld_nxt  = 1'b1;
                        w_tw_addr_nxt = w_tw_addr;
                        w_phase_nxt   = 1'b1;
                    end
                end else begin
                    w_rd_ptr_nxt = w_addr_b;
                    w_rd_en_nxt  = 1'b1;
                    w_phase_nxt  = 1'b0;
                    if (r_bf == BF_LAST) begin
                        w_state_nxt = ST_DRAIN;
                        w_drain_nxt = DRAIN_INIT;
                    end else begin
                        w_bf_nxt = r_bf + (SIZE-1)'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (r_drain == '0) begin
                    if (r_stage == STAGE_LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_stage_nxt = r_stage + STAGE_W'(1);
                        w_bf_nxt    = '0;
                        w_phase_nxt = 1'b0;
                    end
                end else begin
                    w_drain_nxt = r_drain - DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rd_ptr   = r_rd_ptr;
    assign rd_en    = r_rd_en;
    assign bf_valid = r_bf_vld;
    assign tw_addr  = r_tw_addr;
    assign stage    = r_stage;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_fft_stage_controller.sv
`timescale 1ns/1ps
module tb_fft_stage_controller;

    localparam int SIZE     = 3;
    localparam int PIPE_LAT = 4;
    localparam int STAGE_W  = 3;
    localparam int N        = 1 << SIZE;
    localparam int BUDGET   = 300;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               hold;
    logic [SIZE-1:0]    rd_ptr;
    logic               rd_en;
    logic               bf_valid;
    logic [SIZE-2:0]    tw_addr;
    logic [STAGE_W-1:0] stage;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    fft_stage_controller #(
        .SIZE     (SIZE),
        .PIPE_LAT (PIPE_LAT),
        .STAGE_W  (STAGE_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .hold     (hold),
        .rd_ptr   (rd_ptr),
        .rd_en    (rd_en),
        .bf_valid (bf_valid),
        .tw_addr  (tw_addr),
        .stage    (stage),
        .busy     (busy),
        .done     (done)
    );

    typedef struct packed {
        logic [SIZE-1:0]    addr;
        logic               is_a;
        logic [SIZE-2:0]    tw;
        logic [STAGE_W-1:0] stg;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    rd_exp_t last_rd;
    int      gaps[$];
    int      n_total   = 0;
    int      n_pass    = 0;
    int      cyc       = 0;
    int      first_cyc = 0;
    int      done_cyc  = -1;
    int      gap       = 0;
    bit      seen_rd   = 1'b0;
    bit      popped    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference read sequence, built group by group: for stage s the butterflies of a
    // group touch x[g*2*span + p] and x[g*2*span + p + span] with twiddle W^(p*N/(2*span)).
    task automatic push_transform();
        rd_exp_t e;
        int span;
        int groups;
        for (int s = 0; s < SIZE; s++) begin
            span   = 1 << s;
            groups = N / (2 * span);
            for (int g = 0; g < groups; g++) begin
                for (int p = 0; p < span; p++) begin
                    e.addr = SIZE'(g * 2 * span + p);
                    e.is_a = 1'b1;
                    e.tw   = (SIZE-1)'(p * groups);
                    e.stg  = STAGE_W'(s);
                    exp_q.push_back(e);
                    e.addr = SIZE'(g * 2 * span + p + span);
                    e.is_a = 1'b0;
                    e.tw   = '0;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // One clock: sample #1 after the edge, score any read against the queue head.
    task automatic tick();
        rd_exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        popped = 1'b0;
        if (rd_en) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", rd_en, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_ptr", rd_ptr, e.addr);
                chk("bf_valid", bf_valid, e.is_a);
                if (e.is_a) chk("tw_addr", tw_addr, e.tw);
                chk("stage", stage, e.stg);
                last_rd = e;
                popped  = 1'b1;
                if (!seen_rd) begin
                    seen_rd   = 1'b1;
                    first_cyc = cyc;
                end
                if (gap > 0) begin
                    gaps.push_back(gap);
                    gap = 0;
                end
            end
        end else begin
            chk("bf_valid_without_rd", bf_valid, 1'b0);
            if (seen_rd && busy) gap++;
        end
        if (done && done_cyc < 0) done_cyc = cyc;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_ptr"}, rd_ptr, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_bf_valid"}, bf_valid, 0);
        chk({tag, "_tw_addr"}, tw_addr, 0);
        chk({tag, "_stage"}, stage, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic begin_transform();
        push_transform();
        seen_rd  = 1'b0;
        gap      = 0;
        gaps.delete();
        done_cyc = -1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_no_rd_yet", rd_en, 1'b0);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_cyc < 0 && k < BUDGET) begin
            tick();
            k++;
        end
        if (done_cyc < 0) chk("done_timeout", done, 1'b1);
    endtask

    task automatic wait_q_empty();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < BUDGET) begin
            tick();
            k++;
        end
        if (exp_q.size() > 0) chk("queue_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_read(input int stg, input int addr);
        int k;
        bit found;
        k     = 0;
        found = 1'b0;
        while (!found && k < BUDGET) begin
            tick();
            k++;
            if (popped && last_rd.is_a && int'(last_rd.stg) == stg && int'(last_rd.addr) == addr)
                found = 1'b1;
        end
        if (!found) chk("sync_timeout", found, 1'b1);
    endtask

    // Called on the cycle done is visible.
    task automatic finish_checks(input int exp_len, input bit check_gaps);
        chk("queue_drained", exp_q.size(), 0);
        chk("done_latency", done_cyc - first_cyc, exp_len);
        chk("busy_falls_with_done", busy, 1'b0);
        if (check_gaps) begin
            chk("drain_count", gaps.size(), SIZE - 1);
            foreach (gaps[i]) chk("drain_len", gaps[i], PIPE_LAT);
        end
        tick();
        chk("done_one_cycle", done, 1'b0);
        chk("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        logic [SIZE-1:0] held;
        rst   = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        repeat (2) tick();
        chk_zero("reset");

        // start coinciding with reset release is dropped
        rst   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("start_at_release_busy", busy, 1'b0);
        chk("start_at_release_rd_en", rd_en, 1'b0);

        // transform with stray starts during RUN and during DONE
        begin_transform();
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_q_empty();
        repeat (PIPE_LAT) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_on_start_in_done", done, 1'b1);
        finish_checks(SIZE * (N + PIPE_LAT), 1'b1);
        tick();
        chk("start_in_done_ignored_busy", busy, 1'b0);
        chk("start_in_done_ignored_rd", rd_en, 1'b0);

        // hold raised while the A of stage 1 bf 1 is on the bus: B still issues, then 3 stalls
        begin_transform();
        wait_read(1, 1);
        hold = 1'b1;
        tick();
        chk("hold_b_issued", rd_en, 1'b1);
        held = rd_ptr;
        repeat (3) begin
            tick();
            chk("hold_rd_en", rd_en, 1'b0);
            chk("hold_rd_ptr_stable", rd_ptr, held);
        end
        hold = 1'b0;
        wait_done();
        finish_checks(SIZE * (N + PIPE_LAT) + 3, 1'b0);

        // reset during stage 1 bf 2
        begin_transform();
        wait_read(1, 4);
        rst = 1'b1;
        tick();
        chk_zero("midrun_reset");
        exp_q.delete();
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("no_done_after_reset", done, 1'b0);
            chk("no_busy_after_reset", busy, 1'b0);
        end

        // restart from stage 0
        begin_transform();
        wait_done();
        finish_checks(SIZE * (N + PIPE_LAT), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
